// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Holds the FSM state encoding, minimum bit period and parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    localparam int MIN_CLK_DIV = 4;

    // Expected parity bit; zero-extended data does not change the XOR.
    function automatic logic parity_bit(
        input logic [31:0] data,
        input logic        odd
    );
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO for received bytes.
// Head is visible while not empty; reads as zero when empty.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array; contents are only meaningful below count.
    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: synchronizer, framing FSM, mid-bit sampler.
// Good bytes go to a show-ahead FIFO with valid/ready output.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH  = 16,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 uart_rx,
    input  logic [DIV_WIDTH-1:0] cfg_clk_div,
    input  logic                 cfg_parity_en,
    input  logic                 cfg_parity_odd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 err_frame,
    output logic                 err_parity,
    output logic                 err_overrun
);

    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    rx_state_e state;
    rx_state_e state_nx;

    logic                 sync1;
    logic                 sync2;
    logic                 prev;
    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_eff;
    logic [DIV_WIDTH-1:0] target;
    logic [BW-1:0]        bitcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_en_q;
    logic                 par_odd_q;
    logic                 par_err;
    logic                 fall;
    logic                 tick;
    logic                 last_bit;
    logic                 push;
    logic                 set_frame;
    logic                 set_parity;
    logic                 full;
    logic                 empty;
    logic                 pop;

    assign div_eff = (cfg_clk_div < DIV_WIDTH'(MIN_CLK_DIV))
                   ? DIV_WIDTH'(MIN_CLK_DIV) : cfg_clk_div;
    assign target   = (state == START) ? (div_q >> 1) : div_q;
    assign tick     = (cnt == target - 1'b1);
    assign last_bit = (bitcnt == BW'(DATA_BITS - 1));
    assign fall     = prev & ~sync2;
    assign pop      = rx_ready & ~empty;
    assign rx_valid = ~empty;
    assign rx_busy  = (state != IDLE);

    // Two-flop synchronizer plus previous sample for edge detect.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= uart_rx;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and frame-completion decisions.
    always_comb begin
        state_nx   = state;
        push       = 1'b0;
        set_frame  = 1'b0;
        set_parity = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) state_nx = START;
            end
            START: begin
                if (tick) state_nx = sync2 ? IDLE : DATA;
            end
            DATA: begin
                if (tick && last_bit)
                    state_nx = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (tick) state_nx = STOP;
            end
            STOP: begin
                if (tick) begin
                    if (!sync2) begin
                        state_nx  = BREAK;
                        set_frame = 1'b1;
                    end else if (par_err) begin
                        state_nx   = IDLE;
                        set_parity = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        push     = 1'b1;
                    end
                end
            end
            BREAK: begin
                if (sync2) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Baud/bit counters, shift register and per-frame config capture.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt       <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            div_q     <= DIV_WIDTH'(MIN_CLK_DIV);
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_err   <= 1'b0;
        end else if (state == IDLE || state == BREAK) begin
            cnt     <= '0;
            bitcnt  <= '0;
            par_err <= 1'b0;
            if (state == IDLE && fall) begin
                div_q     <= div_eff;
                par_en_q  <= cfg_parity_en;
                par_odd_q <= cfg_parity_odd;
            end
        end else if (tick) begin
            cnt <= '0;
            if (state == DATA) begin
                shreg  <= {sync2, shreg[DATA_BITS-1:1]};
                bitcnt <= bitcnt + 1'b1;
            end
            if (state == PARITY)
                par_err <= sync2 != parity_bit(32'(shreg), par_odd_q);
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // One-cycle error pulses.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_frame   <= set_frame;
            err_parity  <= set_parity;
            err_overrun <= push & full & ~pop;
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .reset     (reset),
        .push      (push),
        .push_data (shreg),
        .pop       (pop),
        .head      (rx_data),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer.
// Directed and randomized frames against a queue-based reference model.
module tb_uart_rx_deserializer;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        uart_rx;
    logic [15:0] cfg_clk_div;
    logic        cfg_parity_en;
    logic        cfg_parity_odd;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_busy;
    logic        err_frame;
    logic        err_parity;
    logic        err_overrun;

    int vectors     = 0;
    int miscompares = 0;
    int n_fe = 0;
    int n_pe = 0;
    int n_ov = 0;
    int fe0, pe0, ov0;
    logic [7:0] q[$];

    uart_rx_deserializer dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .uart_rx        (uart_rx),
        .cfg_clk_div    (cfg_clk_div),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .rx_busy        (rx_busy),
        .err_frame      (err_frame),
        .err_parity     (err_parity),
        .err_overrun    (err_overrun)
    );

    always #5 clk_in = ~clk_in;

    // Count every cycle each error line is high.
    always @(posedge clk_in) begin
        if (err_frame)   n_fe <= n_fe + 1;
        if (err_parity)  n_pe <= n_pe + 1;
        if (err_overrun) n_ov <= n_ov + 1;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Parity bit that makes the frame's ones count even/odd.
    function automatic logic par_of(input logic [7:0] d, input logic odd);
        int ones;
        ones = $countones(d);
        if (odd) return (ones % 2) == 0;
        return (ones % 2) == 1;
    endfunction

    // Drives start, data and parity; returns just after stop is driven.
    task automatic send_frame(input logic [7:0] d, input logic pen,
                              input logic podd, input logic bad_par,
                              input logic stop_v, input int cfg,
                              input int per);
        cfg_clk_div    = 16'(cfg);
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        fe0 = n_fe;
        pe0 = n_pe;
        ov0 = n_ov;
        @(posedge clk_in);
        #1 uart_rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (per) @(posedge clk_in);
            #1 uart_rx = d[i];
        end
        if (pen) begin
            repeat (per) @(posedge clk_in);
            #1 uart_rx = par_of(d, podd) ^ bad_par;
        end
        repeat (per) @(posedge clk_in);
        #1 uart_rx = stop_v;
    endtask

    // Waits out the frame, applies the model and checks the outcome.
    task automatic finish_frame(input logic [7:0] d, input logic pen,
                                input logic podd, input logic bad_par,
                                input logic stop_v, input int per,
                                input string tag);
        int kind;
        repeat (per) @(posedge clk_in);
        if (!stop_v) begin
            repeat (40) @(posedge clk_in);
            #1 uart_rx = 1'b1;
        end
        repeat (per + 4) @(posedge clk_in);
        #1;
        if (!stop_v)                                  kind = 1;
        else if (pen && bad_par)                      kind = 2;
        else if (q.size() == 4)                       kind = 3;
        else begin
            kind = 0;
            q.push_back(d);
        end
        check({tag, ".frame"},   n_fe - fe0, (kind == 1) ? 1 : 0);
        check({tag, ".parity"},  n_pe - pe0, (kind == 2) ? 1 : 0);
        check({tag, ".overrun"}, n_ov - ov0, (kind == 3) ? 1 : 0);
        check({tag, ".busy"}, 32'(rx_busy), 32'(0));
        check({tag, ".valid"}, 32'(rx_valid), 32'(q.size() != 0));
        if (q.size() != 0)
            check({tag, ".head"}, 32'(rx_data), 32'(q[0]));
    endtask

    task automatic frame(input logic [7:0] d, input logic pen,
                         input logic podd, input logic bad_par,
                         input logic stop_v, input int cfg,
                         input string tag);
        int per;
        per = (cfg < 4) ? 4 : cfg;
        send_frame(d, pen, podd, bad_par, stop_v, cfg, per);
        finish_frame(d, pen, podd, bad_par, stop_v, per, tag);
    endtask

    task automatic drain(input string tag);
        while (q.size() != 0) begin
            check({tag, ".pop_valid"}, 32'(rx_valid), 32'(1));
            check({tag, ".pop_data"}, 32'(rx_data), 32'(q[0]));
            rx_ready = 1'b1;
            @(posedge clk_in);
            #1 rx_ready = 1'b0;
            void'(q.pop_front());
        end
        check({tag, ".empty"}, 32'(rx_valid), 32'(0));
    endtask

    initial begin
        int snap;
        reset          = 1'b1;
        uart_rx        = 1'b1;
        rx_ready       = 1'b0;
        cfg_clk_div    = 16'd8;
        cfg_parity_en  = 1'b0;
        cfg_parity_odd = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst.valid", 32'(rx_valid), 32'(0));
        check("rst.busy", 32'(rx_busy), 32'(0));
        check("rst.data", 32'(rx_data), 32'(0));
        check("rst.errs", 32'({err_frame, err_parity, err_overrun}), 32'(0));
        reset = 1'b0;
        repeat (4) @(posedge clk_in);

        // 8N1 0xA5 at div 8; valid exactly one cycle after stop sample.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8, 8);
        repeat (2 + 4) @(posedge clk_in);
        #1 check("a5.pre_valid", 32'(rx_valid), 32'(0));
        @(posedge clk_in);
        #1 check("a5.valid_edge", 32'(rx_valid), 32'(1));
        check("a5.data_edge", 32'(rx_data), 32'hA5);
        finish_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8, "a5");
        drain("a5");

        // Even parity, wrong parity bit.
        frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 8, "par_bad");
        frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8, "par_good_even");
        frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 8, "par_good_odd");
        drain("par");

        // Start-bit glitch of three cycles.
        snap = n_fe + n_pe + n_ov;
        @(posedge clk_in);
        #1 uart_rx = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("glitch.busy_start", 32'(rx_busy), 32'(1));
        uart_rx = 1'b1;
        repeat (5) @(posedge clk_in);
        #1;
        check("glitch.busy_end", 32'(rx_busy), 32'(0));
        check("glitch.valid", 32'(rx_valid), 32'(0));
        check("glitch.errs", n_fe + n_pe + n_ov, snap);

        // Framing error with held-low line, then recovery.
        frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8, "brk");
        frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 8, "after_brk");
        drain("brk");

        // Overrun on fifth byte with consumer stalled.
        for (int i = 1; i <= 5; i++)
            frame(8'(i), 1'b0, 1'b0, 1'b0, 1'b1, 8,
                  $sformatf("ovr%0d", i));
        drain("ovr");

        // Full FIFO with pop in the same cycle as push: no overrun.
        for (int i = 1; i <= 4; i++)
            frame(8'(8'h20 + i), 1'b0, 1'b0, 1'b0, 1'b1, 8,
                  $sformatf("fill%0d", i));
        send_frame(8'h66, 1'b0, 1'b0, 1'b0, 1'b1, 8, 8);
        repeat (2 + 4) @(posedge clk_in);
        #1 check("simul.head", 32'(rx_data), 32'(q[0]));
        rx_ready = 1'b1;
        @(posedge clk_in);
        #1 rx_ready = 1'b0;
        void'(q.pop_front());
        finish_frame(8'h66, 1'b0, 1'b0, 1'b0, 1'b1, 8, "simul");
        drain("simul");

        // Divider below minimum behaves as 4.
        frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1, "div1");
        drain("div1");

        // Reset in the middle of a frame flushes everything.
        frame(8'h3F, 1'b0, 1'b0, 1'b0, 1'b1, 8, "pre_rst");
        snap = n_fe + n_pe + n_ov;
        @(posedge clk_in);
        #1 uart_rx = 1'b0;
        for (int i = 0; i < 3; i++) begin
            repeat (8) @(posedge clk_in);
            #1 uart_rx = i[0] ? 1'b1 : 1'b1 ^ i[1];
        end
        repeat (4) @(posedge clk_in);
        #1 reset = 1'b1;
        uart_rx = 1'b1;
        @(posedge clk_in);
        #1;
        check("midrst.busy", 32'(rx_busy), 32'(0));
        check("midrst.valid", 32'(rx_valid), 32'(0));
        reset = 1'b0;
        q.delete();
        repeat (20) @(posedge clk_in);
        #1 check("midrst.errs", n_fe + n_pe + n_ov, snap);
        frame(8'h88, 1'b0, 1'b0, 1'b0, 1'b1, 8, "post_rst");
        drain("post_rst");

        // Randomized frames.
        for (int n = 0; n < 16; n++) begin
            int per;
            logic pen, podd, badp, stp;
            logic [7:0] d;
            per  = $urandom_range(4, 16);
            pen  = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            badp = pen && ($urandom_range(0, 3) == 0);
            stp  = ($urandom_range(0, 7) != 0);
            d    = 8'($urandom);
            frame(d, pen, podd, badp, stp, per, $sformatf("rnd%0d", n));
            if ($urandom_range(0, 2) == 0) drain($sformatf("rnd%0d", n));
        end
        drain("rnd_end");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
